// File: rtl/conv_burst_writer.sv
// rtl/conv_burst_writer.sv - result FIFO packed into multi-beat bus write bursts inside a granted region
// Optional: CONV_BURST_WRITER_RELU_EN clamps negative results to zero before buffering.
module conv_burst_writer #(
    parameter int          WIDTH      = 32,
    parameter int          ADDR_W     = 28,
    parameter int          FIFO_DEPTH = 16,
    parameter int          MAX_BURST  = 8,
    parameter logic [3:0]  USER_ID    = 4'h0,
    parameter int          REGION_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      result,
    input  logic                  result_en,
    output logic                  result_ready,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [5:0]            addr_bias,
    input  logic [REGION_W-1:0]   region_words,
    input  logic                  addr_en,
    output logic                  addr_rq,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [3:0]            awlen,
    output logic [3:0]            awuser_id,
    output logic                  awuser_ap,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [WIDTH-1:0]      wdata,
    output logic [WIDTH/8-1:0]    wstrb,
    output logic                  wvalid,
    output logic                  wlast,
    input  logic                  wready,
    input  logic [3:0]            wuser_id,
    input  logic                  wuser_last,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int BYTES = WIDTH / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [31:0] MAXB = 32'(MAX_BURST);

    typedef enum logic [1:0] {S_REQ, S_IDLE, S_AW, S_W} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]   cur_q, cur_d, awaddr_q, awaddr_d;
    logic [REGION_W-1:0] rem_q, rem_d;
    logic [3:0]          awlen_q, awlen_d;
    logic [4:0]          beats_q, beats_d, beat_cnt_q, beat_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                overflow_q, overflow_d;
    logic                proto_err_q, proto_err_d;

    logic                full, empty, push, pop, accept, issue, done_flush;
    logic [WIDTH-1:0]    push_data;
    logic [31:0]         cnt32, rem32, cap, burst_n;
    logic [ADDR_W-1:0]   bias_bytes, burst_bytes;
    logic [REGION_W-1:0] rem_left;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign wvalid = (state_q == S_W) && !empty;
    assign accept = wvalid && wready && (wuser_id == USER_ID);
    assign pop    = accept;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push   = result_en && (!full || pop);

`ifdef CONV_BURST_WRITER_RELU_EN
    assign push_data = result[WIDTH-1] ? '0 : result;
`else
    assign push_data = result;
`endif

    assign result_ready = !full;
    assign wdata        = empty ? '0 : mem_q[rd_ptr_q];
    assign wstrb        = wvalid ? {BYTES{1'b1}} : '0;
    assign wlast        = wvalid && (beat_cnt_q == beats_q - 5'd1);
    assign awvalid      = (state_q == S_AW);
    assign awaddr       = awaddr_q;
    assign awlen        = awlen_q;
    assign awuser_id    = USER_ID;
    assign awuser_ap    = 1'b1;
    assign addr_rq      = (state_q == S_REQ);
    assign overflow     = overflow_q;
    assign proto_err    = proto_err_q;
    assign done_flush   = flush_pend_q && empty && ((state_q == S_IDLE) || (state_q == S_REQ));
    assign flush_done   = done_flush;

    // Burst size never exceeds what remains in the region, so bursts stop at its end.
    always_comb begin
        cnt32   = 32'(count_q);
        rem32   = 32'(rem_q);
        cap     = (MAXB < rem32) ? MAXB : rem32;
        burst_n = (cnt32 < cap) ? cnt32 : cap;
        issue   = (cnt32 >= cap) || (flush_pend_q && !empty);
    end

    assign bias_bytes  = ADDR_W'(addr_bias) * ADDR_W'(BYTES);
    assign burst_bytes = ADDR_W'(beats_q) * ADDR_W'(BYTES);
    assign rem_left    = rem_q - REGION_W'(beats_q);

    always_comb begin
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        overflow_d   = overflow_q || (result_en && full && !pop);
        proto_err_d  = proto_err_q || (accept && (wuser_last != wlast));
        flush_pend_d = flush || (flush_pend_q && !done_flush);
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_REQ: begin
                if (addr_en) begin
                    cur_d   = addr + bias_bytes;
                    rem_d   = region_words;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (issue) begin
                    awaddr_d   = cur_q;
                    awlen_d    = 4'(burst_n - 32'd1);
                    beats_d    = 5'(burst_n);
                    beat_cnt_d = '0;
                    state_d    = S_AW;
                end
            end
            S_AW: begin
                if (awready) state_d = S_W;
            end
            S_W: begin
                if (accept) begin
                    if (wlast) begin
                        cur_d      = cur_q + burst_bytes;
                        rem_d      = rem_left;
                        beat_cnt_d = '0;
                        state_d    = (rem_left == '0) ? S_REQ : S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            cur_q        <= '0;
            rem_q        <= '0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            beats_q      <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            cur_q        <= cur_d;
            rem_q        <= rem_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            beats_q      <= beats_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_conv_burst_writer.sv
// tb/tb_conv_burst_writer.sv - randomized bench for conv_burst_writer against a transaction-level model
module tb_conv_burst_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] result;
    logic        result_en;
    logic        result_ready;
    logic [27:0] addr;
    logic [5:0]  addr_bias;
    logic [9:0]  region_words;
    logic        addr_en;
    logic        addr_rq;
    logic        flush;
    logic        flush_done;
    logic [27:0] awaddr;
    logic [3:0]  awlen;
    logic [3:0]  awuser_id;
    logic        awuser_ap;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic [3:0]  wuser_id;
    logic        wuser_last;
    logic        overflow;
    logic        proto_err;

    always #5 clk = ~clk;

    conv_burst_writer dut (
        .clk(clk), .rst_n(rst_n), .result(result), .result_en(result_en),
        .result_ready(result_ready), .addr(addr), .addr_bias(addr_bias),
        .region_words(region_words), .addr_en(addr_en), .addr_rq(addr_rq),
        .flush(flush), .flush_done(flush_done), .awaddr(awaddr), .awlen(awlen),
        .awuser_id(awuser_id), .awuser_ap(awuser_ap), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
        .wlast(wlast), .wready(wready), .wuser_id(wuser_id),
        .wuser_last(wuser_last), .overflow(overflow), .proto_err(proto_err)
    );

`ifdef CONV_BURST_WRITER_RELU_EN
    localparam logic [31:0] NEG_EXP = 32'h0;
`else
    localparam logic [31:0] NEG_EXP = 32'hFFFF_FFF0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_BURST_WRITER_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Transaction-level model: word queue, region cursor, burst bookkeeping.
    logic [31:0] exp_q [$];
    logic [27:0] aw_addrs [$];
    int          aw_lens [$];
    logic [27:0] cur_m;
    int          rem_m, blen, bidx, cap, beat_total, cyc, last_pop_cyc, fd_cnt, fd_cyc;
    bit          ovf_m, perr_m, fp_m, in_burst, acc, req_now, exp_wv, exp_fd;
    logic [31:0] first_wdata;
    int          lie_beat = -1;
    bit          loose = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete(); aw_addrs.delete(); aw_lens.delete();
            ovf_m = 0; perr_m = 0; fp_m = 0; in_burst = 0;
            cur_m = '0; rem_m = 0; blen = 0; bidx = 0;
            beat_total = 0; fd_cnt = 0; fd_cyc = -1; last_pop_cyc = -1;
            first_wdata = '0;
        end else begin
            req_now = (rem_m == 0);
            exp_wv  = in_burst && (exp_q.size() > 0);
            exp_fd  = fp_m && (exp_q.size() == 0) && !in_burst;
            check("result_ready", result_ready, exp_q.size() < 16);
            check("overflow", overflow, ovf_m);
            check("proto_err", proto_err, perr_m);
            check("addr_rq", addr_rq, req_now);
            check("flush_done", flush_done, exp_fd);
            check("wvalid", wvalid, exp_wv);
            check("wstrb", wstrb, exp_wv ? 4'hF : 4'h0);
            check("wlast", wlast, exp_wv && (bidx == blen - 1));
            if (exp_wv) check("wdata", wdata, exp_q[0]);
            check("awuser_id", awuser_id, 4'h0);
            check("awuser_ap", awuser_ap, 1'b1);
            check("aw_in_burst", awvalid && in_burst, 1'b0);
            if (!in_burst && awvalid && awready) begin
                cap = (rem_m < 8) ? rem_m : 8;
                check("awaddr", awaddr, cur_m);
                if (loose) check("awlen_range", (int'(awlen) + 1) <= cap, 1'b1);
                else       check("awlen", awlen, cap - 1);
                aw_addrs.push_back(awaddr);
                aw_lens.push_back(int'(awlen));
                in_burst = 1; blen = int'(awlen) + 1; bidx = 0;
            end
            acc = exp_wv && wready && (wuser_id == 4'h0);
            if (acc) begin
                if (wuser_last != (bidx == blen - 1)) perr_m = 1;
                if (beat_total == 0) first_wdata = wdata;
                void'(exp_q.pop_front());
                beat_total++;
                last_pop_cyc = cyc;
                bidx++;
                if (bidx == blen) begin
                    in_burst = 0;
                    cur_m = cur_m + 28'(blen * 4);
                    rem_m = rem_m - blen;
                end
            end
            if (result_en) begin
                if (exp_q.size() < 16) exp_q.push_back(relu(result));
                else ovf_m = 1;
            end
            if (addr_en && req_now) begin
                cur_m = addr + 28'(addr_bias) * 28'd4;
                rem_m = int'(region_words);
            end
            fp_m = flush || (fp_m && !exp_fd);
            if (flush_done) begin fd_cnt++; fd_cyc = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        result_en  = 0;
        addr_en    = 0;
        flush      = 0;
        wuser_last = in_burst && ((bidx == blen - 1) ^ (bidx == lie_beat));
    endtask

    task automatic push_word(input logic [31:0] v);
        result = v; result_en = 1; tick();
    endtask

    task automatic load_region(input logic [27:0] a, input logic [5:0] b, input logic [9:0] r);
        addr = a; addr_bias = b; region_words = r; addr_en = 1; tick();
    endtask

    task automatic wait_beats(input int n, input int limit, input string tag);
        int k = 0;
        while (beat_total < n && k < limit) begin tick(); k++; end
        check(tag, beat_total >= n, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 0; result_en = 0; addr_en = 0; flush = 0; wuser_last = 0;
        awready = 1; wready = 1; wuser_id = 0; lie_beat = -1; loose = 0;
        #1;
        check("rst_addr_rq", addr_rq, 1'b1);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_awaddr", awaddr, 28'h0);
        check("rst_awlen", awlen, 4'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_result_ready", result_ready, 1'b1);
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        result = '0; addr = '0; addr_bias = '0; region_words = '0;

        do_reset();
        load_region(28'h100, 6'd2, 10'd64);
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        wait_beats(8, 100, "p1_beats");
        check("p1_aw_count", aw_addrs.size(), 1);
        check("p1_awaddr", aw_addrs[0], 28'h108);
        check("p1_awlen", aw_lens[0], 7);
        check("p1_first_wdata", first_wdata, 32'h1);
        for (int i = 9; i <= 16; i++) push_word(32'(i));
        wait_beats(16, 100, "p1_beats2");
        check("p1_awaddr2", aw_addrs[1], 28'h128);

        do_reset();
        load_region(28'h200, 6'd0, 10'd5);
        for (int i = 0; i < 5; i++) push_word(32'(100 + i));
        wait_beats(5, 100, "p2_beats");
        check("p2_awlen", aw_lens[0], 4);
        check("p2_addr_rq", addr_rq, 1'b1);
        for (int i = 0; i < 3; i++) push_word(32'(200 + i));
        repeat (20) tick();
        check("p2_no_burst", aw_addrs.size(), 1);
        load_region(28'h400, 6'd0, 10'd3);
        wait_beats(8, 100, "p2_beats2");
        check("p2_aw_count", aw_addrs.size(), 2);
        check("p2_awaddr2", aw_addrs[1], 28'h400);
        check("p2_awlen2", aw_lens[1], 2);

        do_reset();
        loose = 1;
        load_region(28'h1000, 6'd0, 10'd64);
        push_word(32'hFFFF_FFF0); push_word(32'd5); push_word(32'd7);
        repeat (10) tick();
        check("p3_no_burst", aw_addrs.size(), 0);
        flush = 1; tick();
        wait_beats(3, 100, "p3_beats");
        repeat (5) tick();
        check("p3_awlen", aw_lens[0], 2);
        check("p3_fd_count", fd_cnt, 1);
        check("p3_fd_timing", fd_cyc, last_pop_cyc + 1);
        check("p3_relu_wdata", first_wdata, NEG_EXP);
        flush = 1; tick();
        check("p3_fd_empty", flush_done, 1'b1);
        tick();
        check("p3_fd_once", flush_done, 1'b0);

        do_reset();
        wready = 0;
        load_region(28'h0, 6'd0, 10'd64);
        for (int i = 0; i < 17; i++) push_word($urandom);
        check("p4_overflow", overflow, 1'b1);
        check("p4_ready", result_ready, 1'b0);
        wready = 1;
        wait_beats(16, 200, "p4_beats");
        repeat (20) tick();
        check("p4_exact16", beat_total, 16);

        do_reset();
        load_region(28'h0, 6'd0, 10'd64);
        wuser_id = 4'h1;
        for (int i = 0; i < 8; i++) push_word(32'(i + 50));
        repeat (20) tick();
        check("p5_no_pop", beat_total, 0);
        check("p5_wvalid", wvalid, 1'b1);
        lie_beat = 2;
        wuser_id = 4'h0;
        wait_beats(8, 100, "p5_beats");
        check("p5_proto_err", proto_err, 1'b1);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            result_en = ($urandom % 3) != 0;
            result    = $urandom;
            awready   = $urandom % 2;
            wready    = ($urandom % 4) != 0;
            wuser_id  = (($urandom % 8) == 0) ? 4'h1 : 4'h0;
            if (($urandom % 4) == 0) begin
                addr = 28'($urandom); addr_bias = 6'($urandom);
                region_words = 10'($urandom_range(1, 40)); addr_en = 1;
            end
            tick();
        end
        loose = 1; awready = 1; wready = 1; wuser_id = 0;
        flush = 1; tick();
        for (int c = 0; c < 3000 && (exp_q.size() > 0 || in_burst); c++) begin
            if (($urandom % 4) == 0) begin
                addr = 28'($urandom); addr_bias = 6'($urandom);
                region_words = 10'($urandom_range(1, 40)); addr_en = 1;
            end
            tick();
        end
        check("rand_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
